ascii_hex_record_parser: RTL and testbench
==========================================

# ascii_hex_record_parser

Parses a stream of ASCII characters into records of up to NumFields hex fields, each up to NumDigits digits, and emits each completed record as a packed word. It sits between the UART receive path and the command/register decoders. It replaces single-value hex shifting with delimited multi-field records, valid/ready flow control on both sides, and coded error reporting with resynchronisation.

## Interface
- NumDigits, 4, maximum hex digits per field; W = 4*NumDigits bits per field; NumDigits ≥ 1
- NumFields, 3, maximum fields per record; NumFields ≥ 1
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  in_char is valid
- in_ready  out  1  parser accepts in_char this cycle; a char is accepted when in_valid && in_ready
- in_char  in  8  ASCII character
- out_valid  out  1  record available
- out_ready  in  1  consumer takes the record; the handshake completes when out_valid && out_ready
- out_fields  out  W*NumFields  field i at [i*W +: W]; field 0 is the first field received
- out_count  out  $clog2(NumFields+1)  number of fields in the record (1..NumFields)
- err_pulse  out  1  one-cycle pulse when an error is detected
- err_code  out  2  1 = invalid char, 2 = digit overflow, 3 = too many fields; holds its last value between pulses

## Operation
- Character classes:
  - HEX: 0-9, A-F, a-f (case-insensitive).
  - SEP: space and ','.
  - TERM: ';', CR (0x0D), LF (0x0A).
  - BAD: everything else.
- States:
  - IDLE: no field open in the current record.
  - FIELD: accumulating digits.
  - GAP: at least one field closed, no field open.
  - DISCARD: error recovery.
  - HOLD: record presented on the output.
- IDLE:
  - HEX: open field 0, digit count = 1, go to FIELD.
  - SEP or TERM: ignored, so leading delimiters and empty records produce no output.
  - BAD: error 1.
- FIELD:
  - HEX: shift the nibble in at the LSB end (acc = acc<<4 | nibble). If the field already holds NumDigits digits, raise error 2.
  - SEP: close the field, go to GAP.
  - TERM: close the field, go to HOLD.
  - BAD: error 1.
- GAP:
  - HEX: open the next field. If NumFields fields are already closed, raise error 3.
  - SEP: ignored; runs of separators are allowed.
  - TERM: go to HOLD.
  - BAD: error 1.
- Field values are right-justified and zero-extended. Fields not received in a record read as 0.
- Closing field k sets out_count = k+1.
- On any error:
  - err_pulse = 1 for one cycle with err_code set.
  - Partial record is dropped; go to DISCARD.
- DISCARD:
  - Every char is accepted and ignored until a TERM arrives, then go to IDLE.
  - No further errors are reported while in DISCARD.
- HOLD:
  - out_valid = 1; out_fields and out_count are stable.
  - in_ready = 0.
  - When out_ready is sampled high: clear the accumulators and out_count, go to IDLE.
- in_ready = 1 in every state except HOLD, and 0 while reset is asserted.

## Timing
- All outputs are registered except in_ready, which decodes the state register combinationally.
- Reset (1 cycle sufficient, any state including mid-record or HOLD):
  - state = IDLE.
  - out_valid = 0, out_fields = 0, out_count = 0, err_pulse = 0, err_code = 0.
  - Partial data is discarded.
- Terminator accepted at cycle N gives out_valid = 1 at N+1. A record with zero fields never asserts out_valid.
- Handshake completes at cycle M: out_valid = 0 and in_ready = 1 at M+1. With out_ready held high, minimum record spacing is the character count + 1 cycle.
- Offending char accepted at cycle N gives err_pulse = 1 at N+1 only.
- A TERM that causes an error cannot occur, because TERM is never an error.
- in_valid gaps of any length are allowed; state persists across them.

## Structure
- Package ascii_hex_pkg holds:
  - char class encoding: CLS_HEX, CLS_SEP, CLS_TERM, CLS_BAD
  - state encoding
  - error codes: ERR_NONE = 0, ERR_CHAR = 1, ERR_OVF = 2, ERR_FIELDS = 3
  - delimiter constants
- One sub-module, ascii_hex_classify: purely combinational, in_char → {class, nibble[3:0]}. It is reusable by other ASCII front ends.
- The top level contains:
  - the FSM
  - digit counter ($clog2(NumDigits+1) bits)
  - field index counter
  - per-field accumulators

## Test plan
All scenarios use NumDigits = 4 and NumFields = 3.
- "12 ab;" with out_ready = 1 → one record: fields 0x0012, 0x00AB, 0x0000; out_count = 2; out_valid one cycle after ';'.
- "1,2,3\n" with out_ready low for 5 cycles → out_valid and fields held stable, in_ready = 0 throughout; following "4;" is not lost and gives field0 = 0x0004, out_count = 1.
- "12345;7;" → err_pulse with code 2 one cycle after '5'; no record for the first line; then a record with field0 = 0x0007.
- "1 2 3 4;" → code 3 at the '4'. "1 G x;" → exactly one pulse with code 1, no record; the next "F;" gives field0 = 0x000F.
- ";; \r\n" → no out_valid and no err_pulse. Random in_valid gaps on "aB cD;" → fields 0x00AB, 0x00CD.
- Feed "12" then reset for 1 cycle, then "3;" → single record with field0 = 0x0003, out_count = 1. Reset during HOLD → out_valid drops the next cycle.

Source files
------------

// File: rtl/ascii_hex_pkg.sv
// Shared encodings for the ASCII hex record parser: character classes,
// FSM states, error codes and delimiter characters.
package ascii_hex_pkg;

    typedef enum logic [1:0] {
        CLS_HEX  = 2'd0,
        CLS_SEP  = 2'd1,
        CLS_TERM = 2'd2,
        CLS_BAD  = 2'd3
    } char_cls_e;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FIELD   = 3'd1;
    localparam logic [2:0] ST_GAP     = 3'd2;
    localparam logic [2:0] ST_DISCARD = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_CHAR   = 2'd1;
    localparam logic [1:0] ERR_OVF    = 2'd2;
    localparam logic [1:0] ERR_FIELDS = 2'd3;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_SEMI  = 8'h3B;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

endpackage

// File: rtl/ascii_hex_classify.sv
// Combinational ASCII classifier: maps a character to its class and,
// for hex digits, the nibble value (case-insensitive).
module ascii_hex_classify
    import ascii_hex_pkg::*;
(
    input  logic [7:0] in_char,
    output char_cls_e  cls_c,
    output logic [3:0] nibble_c
);

    always_comb begin
        cls_c    = CLS_BAD;
        nibble_c = 4'd0;
        if (in_char >= 8'h30 && in_char <= 8'h39) begin
            cls_c    = CLS_HEX;
            nibble_c = 4'(in_char - 8'h30);
        end else if (in_char >= 8'h41 && in_char <= 8'h46) begin
            cls_c    = CLS_HEX;
            nibble_c = 4'(in_char - 8'h37);
        end else if (in_char >= 8'h61 && in_char <= 8'h66) begin
            cls_c    = CLS_HEX;
            nibble_c = 4'(in_char - 8'h57);
        end else if (in_char == CH_SPACE || in_char == CH_COMMA) begin
            cls_c = CLS_SEP;
        end else if (in_char == CH_SEMI || in_char == CH_CR || in_char == CH_LF) begin
            cls_c = CLS_TERM;
        end
    end

endmodule

// File: rtl/ascii_hex_record_parser.sv
// Parses delimited ASCII hex fields into packed records with valid/ready
// flow control and coded error reporting with resync on a terminator.
module ascii_hex_record_parser
    import ascii_hex_pkg::*;
#(
    parameter int unsigned NumDigits = 4,
    parameter int unsigned NumFields = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [7:0]                         in_char,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [4*NumDigits*NumFields-1:0]   out_fields,
    output logic [$clog2(NumFields+1)-1:0]     out_count,
    output logic                               err_pulse,
    output logic [1:0]                         err_code
);

    localparam int unsigned W   = 4 * NumDigits;
    localparam int unsigned DCW = $clog2(NumDigits + 1);
    localparam int unsigned FCW = $clog2(NumFields + 1);

    logic [2:0]     state_q, state_d;
    logic [DCW-1:0] dig_cnt_q, dig_cnt_d;
    logic [FCW-1:0] fld_cnt_q, fld_cnt_d;
    logic [W-1:0]   acc_q [NumFields];
    logic [W-1:0]   acc_d [NumFields];
    logic           out_valid_q, out_valid_d;
    logic           err_pulse_q, err_pulse_d;
    logic [1:0]     err_code_q, err_code_d;

    char_cls_e  cls;
    logic [3:0] nibble;
    logic       accept;
    logic       err;
    logic [1:0] code;

    ascii_hex_classify u_classify (
        .in_char  (in_char),
        .cls_c    (cls),
        .nibble_c (nibble)
    );

    assign in_ready = !reset && (state_q != ST_HOLD);
    assign accept   = in_valid && (state_q != ST_HOLD);

    // Next-state, field accumulation and error detection.
    always_comb begin
        state_d     = state_q;
        dig_cnt_d   = dig_cnt_q;
        fld_cnt_d   = fld_cnt_q;
        acc_d       = acc_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        err         = 1'b0;
        code        = ERR_NONE;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cls)
                        CLS_HEX: begin
                            acc_d[0]  = W'(nibble);
                            dig_cnt_d = DCW'(1);
                            state_d   = ST_FIELD;
                        end
                        CLS_BAD: begin
                            err  = 1'b1;
                            code = ERR_CHAR;
                        end
                        default: ;
                    endcase
                end
            end
            ST_FIELD: begin
                if (accept) begin
                    case (cls)
                        CLS_HEX: begin
                            if (dig_cnt_q == DCW'(NumDigits)) begin
                                err  = 1'b1;
                                code = ERR_OVF;
                            end else begin
                                for (int unsigned i = 0; i < NumFields; i++) begin
                                    if (fld_cnt_q == FCW'(i)) begin
                                        acc_d[i] = W'({acc_q[i], nibble});
                                    end
                                end
                                dig_cnt_d = dig_cnt_q + DCW'(1);
                            end
                        end
                        CLS_SEP: begin
                            fld_cnt_d = fld_cnt_q + FCW'(1);
                            state_d   = ST_GAP;
                        end
                        CLS_TERM: begin
                            fld_cnt_d = fld_cnt_q + FCW'(1);
                            state_d   = ST_HOLD;
                        end
                        default: begin
                            err  = 1'b1;
                            code = ERR_CHAR;
                        end
                    endcase
                end
            end
            ST_GAP: begin
                if (accept) begin
                    case (cls)
                        CLS_HEX: begin
                            if (fld_cnt_q == FCW'(NumFields)) begin
                                err  = 1'b1;
                                code = ERR_FIELDS;
                            end else begin
                                for (int unsigned i = 0; i < NumFields; i++) begin
                                    if (fld_cnt_q == FCW'(i)) begin
                                        acc_d[i] = W'(nibble);
                                    end
                                end
                                dig_cnt_d = DCW'(1);
                                state_d   = ST_FIELD;
                            end
                        end
                        CLS_TERM: state_d = ST_HOLD;
                        CLS_BAD: begin
                            err  = 1'b1;
                            code = ERR_CHAR;
                        end
                        default: ;
                    endcase
                end
            end
            ST_DISCARD: begin
                if (accept && cls == CLS_TERM) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    for (int unsigned i = 0; i < NumFields; i++) begin
                        acc_d[i] = '0;
                    end
                    fld_cnt_d = '0;
                    dig_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Any error drops the partial record and waits for a terminator.
        if (err) begin
            for (int unsigned i = 0; i < NumFields; i++) begin
                acc_d[i] = '0;
            end
            fld_cnt_d   = '0;
            dig_cnt_d   = '0;
            err_pulse_d = 1'b1;
            err_code_d  = code;
            state_d     = ST_DISCARD;
        end

        out_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dig_cnt_q   <= '0;
            fld_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            for (int unsigned i = 0; i < NumFields; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            dig_cnt_q   <= dig_cnt_d;
            fld_cnt_q   <= fld_cnt_d;
            out_valid_q <= out_valid_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            for (int unsigned i = 0; i < NumFields; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    for (genvar g = 0; g < NumFields; g++) begin : g_fields
        assign out_fields[g*W +: W] = acc_q[g];
    end

    assign out_count = fld_cnt_q;
    assign out_valid = out_valid_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_ascii_hex_record_parser.sv
// Directed and random character streams checked against a record-level
// reference model of the parser.
module tb_ascii_hex_record_parser;

    localparam int ND = 4;
    localparam int NF = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_fields;
    logic [1:0]  out_count;
    logic        err_pulse;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_discard;
    bit          m_open;
    int          m_nf;
    int          m_len;
    int          m_vals [NF];
    logic [1:0]  m_code;

    bit          use_gaps;
    bit          auto_ack;
    bit          pending;
    int          hold_n;
    logic [47:0] rec_fields;
    logic [1:0]  rec_count;

    ascii_hex_record_parser #(.NumDigits(ND), .NumFields(NF)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_fields (out_fields),
        .out_count  (out_count),
        .err_pulse  (err_pulse),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 0 = hex, 1 = separator, 2 = terminator, 3 = bad
    function automatic int cls_of(input logic [7:0] c, output int nib);
        nib = 0;
        if (c >= "0" && c <= "9") begin nib = int'(c) - int'("0"); return 0; end
        if (c >= "A" && c <= "F") begin nib = int'(c) - int'("A") + 10; return 0; end
        if (c >= "a" && c <= "f") begin nib = int'(c) - int'("a") + 10; return 0; end
        if (c == " " || c == ",") return 1;
        if (c == ";" || c == 8'h0D || c == 8'h0A) return 2;
        return 3;
    endfunction

    task automatic model_clear();
        m_open = 0;
        m_nf   = 0;
        m_len  = 0;
        for (int i = 0; i < NF; i++) m_vals[i] = 0;
    endtask

    task automatic model_reset();
        m_discard = 0;
        m_code    = 2'd0;
        model_clear();
    endtask

    task automatic model_char(input logic [7:0] c, output bit e, output bit rec);
        int k;
        int n;
        e   = 0;
        rec = 0;
        k   = cls_of(c, n);
        if (m_discard) begin
            if (k == 2) m_discard = 0;
            return;
        end
        case (k)
            0: begin
                if (m_open) begin
                    if (m_len == ND) begin e = 1; m_code = 2'd2; end
                    else begin m_vals[m_nf] = m_vals[m_nf] * 16 + n; m_len++; end
                end else if (m_nf == NF) begin
                    e = 1; m_code = 2'd3;
                end else begin
                    m_open = 1; m_vals[m_nf] = n; m_len = 1;
                end
            end
            1: if (m_open) begin m_open = 0; m_nf++; end
            2: begin
                if (m_open) begin m_open = 0; m_nf++; end
                if (m_nf > 0) begin
                    rec        = 1;
                    rec_fields = {16'(m_vals[2]), 16'(m_vals[1]), 16'(m_vals[0])};
                    rec_count  = 2'(m_nf);
                    model_clear();
                end
            end
            default: begin e = 1; m_code = 2'd1; end
        endcase
        if (e) begin
            m_discard = 1;
            model_clear();
        end
    endtask

    task automatic ack();
        int n;
        n = (hold_n >= 0) ? hold_n : int'($urandom_range(0, 4));
        for (int i = 0; i < n; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_char   = "G";
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_fields", out_fields, rec_fields);
            chk("hold_count", out_count, rec_count);
            chk("hold_err", err_pulse, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ack_valid", out_valid, 0);
        chk("ack_in_ready", in_ready, 1);
        chk("ack_count", out_count, 0);
        chk("ack_fields", out_fields, 0);
        pending = 0;
    endtask

    task automatic send_char(input logic [7:0] c);
        bit e;
        bit rec;
        int g;
        g = use_gaps ? int'($urandom_range(0, 3)) : 0;
        for (int i = 0; i < g; i++) begin
            @(posedge clk); #1;
            chk("gap_err", err_pulse, 0);
            chk("gap_valid", out_valid, 0);
        end
        in_char  = c;
        in_valid = 1'b1;
        chk("in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_char(c, e, rec);
        chk("err_pulse", err_pulse, e);
        chk("err_code", err_code, m_code);
        chk("out_valid", out_valid, rec);
        if (rec) begin
            chk("rec_fields", out_fields, rec_fields);
            chk("rec_count", out_count, rec_count);
            chk("rec_in_ready", in_ready, 0);
            pending = 1;
            if (auto_ack) ack();
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        model_reset();
        pending = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_fields", out_fields, 0);
        chk("rst_in_ready_rel", in_ready, 1);
    endtask

    initial begin
        string alpha;
        string rs;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        out_ready = 1'b0;
        use_gaps  = 0;
        auto_ack  = 1;
        hold_n    = 0;
        pending   = 0;
        model_reset();
        do_reset();

        // record with immediate consumption
        send_str("12 ab;");

        // consumer stalls five cycles; following record still arrives
        hold_n = 5;
        send_str("1,2,3\n");
        hold_n = -1;
        send_str("4;");

        // digit overflow, field overflow, bad characters
        send_str("12345;7;");
        send_str("1 2 3 4;");
        send_str("1 G x;");
        send_str("F;");

        // delimiter-only lines produce nothing
        send_str(";; \r\n");

        // input gaps
        use_gaps = 1;
        send_str("aB cD;");
        use_gaps = 0;

        // reset mid-record
        send_str("12");
        do_reset();
        send_str("3;");

        // reset while a record is held
        auto_ack = 0;
        send_str("5;");
        do_reset();
        auto_ack = 1;

        // random streams
        alpha    = "0123456789abcdefABCDEF ,,;;\r\nGz";
        use_gaps = 1;
        for (int i = 0; i < 400; i++) begin
            rs = alpha;
            send_char(rs[$urandom_range(0, alpha.len() - 1)]);
        end
        send_str(";");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
